// File: rtl/scrambler_par.sv
// -----------------------------------------------------------------------------
// scrambler_par
//   Parallel LFSR scrambler/descrambler. Each accepted word of DATA_W bits is
//   processed as DATA_W serial bit steps, all done combinationally in one
//   cycle. Bit 0 of a word is the earliest serial bit. Two modes are
//   supported: additive (frame-synchronous) and multiplicative
//   (self-synchronising). The result is registered and presented behind a
//   valid/ready handshake, with a latency of one cycle from accept.
//
// Parameters
//   DATA_W  bits per word (1..64)
//   LFSR_W  LFSR length (2..32)
//   POLY    tap mask, bit k-1 set means stage s_k feeds back
//   SEED    LFSR value loaded on reset
//
// Ports
//   clk, rst             clock; asynchronous active-high reset
//   mode                 0 = additive, 1 = multiplicative
//   dir                  0 = scramble, 1 = descramble (multiplicative only)
//   seed_load, seed_val  load a runtime seed into the LFSR
//   in_valid, in_ready   input handshake, data_in is the input word
//   out_valid, out_ready output handshake, data_out is the result word
//   state_out            current LFSR state, state_out[k-1] = s_k
//   bypass               (SCRAMBLER_BYPASS_EN only) pass data through and
//                        hold the LFSR for the accepted word
//
// Build option
//   SCRAMBLER_BYPASS_EN  adds the bypass input port
// -----------------------------------------------------------------------------
module scrambler_par #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       LFSR_W = 7,
  parameter logic [LFSR_W-1:0] POLY   = 7'b1001000,
  parameter logic [LFSR_W-1:0] SEED   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              dir,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
`ifdef SCRAMBLER_BYPASS_EN
  input  logic              bypass,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [LFSR_W-1:0] state_out
);

  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] start_state;
  logic [LFSR_W-1:0] next_state;
  logic [DATA_W-1:0] scr_word;
  logic [LFSR_W-1:0] s;
  logic              fb;
  logic              shift_bit;
  logic              accept;
  logic              bypass_en;

`ifdef SCRAMBLER_BYPASS_EN
  assign bypass_en = bypass;
`else
  assign bypass_en = 1'b0;
`endif

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign state_out = lfsr;

  // A seed load in the same cycle as an accept becomes the starting state for
  // that word, so the word is processed from seed_val.
  assign start_state = seed_load ? seed_val : lfsr;

  // Unrolled serial bit steps: bit 0 first, shift toward s_LFSR_W.
  always_comb begin
    s         = start_state;
    scr_word  = '0;
    fb        = 1'b0;
    shift_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      fb          = ^(s & POLY);
      scr_word[i] = data_in[i] ^ fb;
      if (!mode)
        shift_bit = fb;
      else if (!dir)
        shift_bit = scr_word[i];
      else
        shift_bit = data_in[i];
      s = {s[LFSR_W-2:0], shift_bit};
    end
    next_state = s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      lfsr      <= SEED;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        if (bypass_en) begin
          data_out <= data_in;
          lfsr     <= start_state;
        end else begin
          data_out <= scr_word;
          lfsr     <= next_state;
        end
      end else begin
        if (out_ready)
          out_valid <= 1'b0;
        // Holds unless a seed load is pending; data_out is left untouched.
        lfsr <= start_state;
      end
    end
  end

endmodule
